thumb_uart_upscale: RTL and testbench

Receive-side counterpart of the 32×32 block-average resizer. It accepts the 1024-byte averaged grayscale thumbnail arriving over the UART receiver, one byte per block in row-major order, and stores it in a double-buffered on-chip RAM. It serves the thumbnail to the 640×480 VGA path as a nearest-neighbour 20×15 upscale, and swaps buffers only on a vertical sync so the display never tears.

---
 rtl/thumb_uart_upscale.sv | 130 +++++++++++++
 tb/tb_thumb_uart_upscale.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/thumb_uart_upscale.sv
// thumb_uart_upscale: receives a BLK_W x BLK_H grayscale thumbnail over the UART
// into the back half of a double-buffered RAM. It serves the front half to the VGA
// path as a nearest-neighbour SCALE_X x SCALE_Y upscale, and swaps halves on vsync.
module thumb_uart_upscale #(
   parameter int BLK_W   = 32,
   parameter int BLK_H   = 32,
   parameter int SCALE_X = 20,
   parameter int SCALE_Y = 15,
   parameter int TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_rdy,
   input  logic [7:0] rx_data,
   output logic       clr_rx_rdy,
   input  logic       vsync_pulse,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   output logic [7:0] pix_gray,
   output logic       frame_valid,
   output logic [7:0] frame_cnt,
   output logic       rx_err
);

   localparam int DEPTH  = BLK_W * BLK_H;
   localparam int AW     = $clog2(DEPTH);
   localparam int DISP_W = BLK_W * SCALE_X;
   localparam int DISP_H = BLK_H * SCALE_Y;
   localparam int TW     = $clog2(TIMEOUT + 1);

   typedef enum logic {ST_RX, ST_PEND} state_t;

   state_t        state;
   logic [7:0]    mem [0:(2**(AW+1))-1];
   logic [AW-1:0] idx;
   logic          bank_sel;
   logic [TW-1:0] idle;
   logic          offer;
   logic [9:0]    bx;
   logic [9:0]    by;
   logic [AW-1:0] addr_c;
   logic          in_range;
   logic [AW-1:0] addr_q;
   logic          mask_q;

   // A held rx_rdy is only taken once: the acknowledge cycle masks it.
   assign offer = rx_rdy && !clr_rx_rdy;

   // Receive FSM: byte counting, idle timeout, PEND drops and vsync-aligned bank swap.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RX;
         idx         <= '0;
         bank_sel    <= 1'b0;
         idle        <= '0;
         clr_rx_rdy  <= 1'b0;
         frame_valid <= 1'b0;
         frame_cnt   <= '0;
         rx_err      <= 1'b0;
      end else begin
         clr_rx_rdy <= offer;
         rx_err     <= 1'b0;
         case (state)
            ST_RX: begin
               if (offer) begin
                  idle <= '0;
                  if (idx == AW'(DEPTH - 1)) begin
                     idx   <= '0;
                     state <= ST_PEND;
                  end else begin
                     idx <= idx + AW'(1);
                  end
               end else if (idx != '0) begin
                  if (idle == TW'(TIMEOUT)) begin
                     idx    <= '0;
                     idle   <= '0;
                     rx_err <= 1'b1;
                  end else begin
                     idle <= idle + TW'(1);
                  end
               end else begin
                  idle <= '0;
               end
            end
            ST_PEND: begin
               idle <= '0;
               if (offer) rx_err <= 1'b1;
               if (vsync_pulse) begin
                  bank_sel    <= ~bank_sel;
                  frame_valid <= 1'b1;
                  frame_cnt   <= frame_cnt + 8'd1;
                  state       <= ST_RX;
               end
            end
            default: state <= ST_RX;
         endcase
      end
   end

   // Back-bank write on the accepting edge; RAM contents are never reset.
   always_ff @(posedge clk) begin
      if (!rst && state == ST_RX && offer) mem[{~bank_sel, idx}] <= rx_data;
   end

   // Block coordinate from display coordinate (constant divisors, exact).
   always_comb begin
      bx       = pix_x / 10'(SCALE_X);
      by       = pix_y / 10'(SCALE_Y);
      addr_c   = AW'(int'(by) * BLK_W + int'(bx));
      in_range = (pix_x < 10'(DISP_W)) && (pix_y < 10'(DISP_H));
   end

   // Read stage 1: register block address and the visibility mask.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         mask_q <= 1'b0;
      end else begin
         addr_q <= addr_c;
         mask_q <= in_range && frame_valid;
      end
   end

   // Read stage 2: register the front-bank RAM output, forced to 0 when masked.
   always_ff @(posedge clk) begin
      if (rst) pix_gray <= '0;
      else     pix_gray <= mask_q ? mem[{bank_sel, addr_q}] : '0;
   end

endmodule

// File: tb/tb_thumb_uart_upscale.sv
// Testbench for thumb_uart_upscale: random stimulus against an image-level reference model.
module tb_thumb_uart_upscale;

   localparam int TO = 300;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_rdy;
   logic [7:0] rx_data;
   logic       clr_rx_rdy;
   logic       vsync_pulse;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic [7:0] pix_gray;
   logic       frame_valid;
   logic [7:0] frame_cnt;
   logic       rx_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int clr_cnt = 0;
   int err_cnt = 0;
   int last_err_cyc = -1;
   int last_acc = 0;

   // Reference model: what was sent, what is displayed.
   logic [7:0] ref_back [1024];
   logic [7:0] ref_front[1024];
   bit ref_valid;
   bit ref_pend;
   int ref_idx;
   int ref_cnt;

   always #5 clk = ~clk;

   thumb_uart_upscale #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
      .vsync_pulse(vsync_pulse), .pix_x(pix_x), .pix_y(pix_y), .pix_gray(pix_gray),
      .frame_valid(frame_valid), .frame_cnt(frame_cnt), .rx_err(rx_err)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (clr_rx_rdy) clr_cnt++;
      if (rx_err) begin
         err_cnt++;
         last_err_cyc = cyc;
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] exp_pix(input int x, input int y);
      if (!ref_valid || x >= 640 || y >= 480) return 8'h00;
      return ref_front[(y / 15) * 32 + x / 20];
   endfunction

   task automatic model_reset();
      ref_valid = 0; ref_pend = 0; ref_idx = 0; ref_cnt = 0;
   endtask

   task automatic send_byte(input logic [7:0] d);
      @(negedge clk);
      rx_rdy = 1'b1; rx_data = d;
      last_acc = cyc + 1;
      @(negedge clk);
      rx_rdy = 1'b0; rx_data = 8'($urandom);
      if (!ref_pend) begin
         ref_back[ref_idx] = d;
         ref_idx++;
         if (ref_idx == 1024) begin ref_idx = 0; ref_pend = 1; end
      end
   endtask

   task automatic do_vsync();
      @(negedge clk); vsync_pulse = 1'b1;
      @(negedge clk); vsync_pulse = 1'b0;
      if (ref_pend) begin
         ref_front = ref_back; ref_valid = 1; ref_pend = 0; ref_cnt = (ref_cnt + 1) % 256;
      end
   endtask

   task automatic read_pix(input int x, input int y, output logic [7:0] v);
      @(negedge clk); pix_x = 10'(x); pix_y = 10'(y);
      @(negedge clk);
      @(negedge clk); v = pix_gray;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      rst = 1'b1; rx_rdy = 1'b0; rx_data = '0; vsync_pulse = 1'b0; pix_x = '0; pix_y = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %0b expected 0", frame_valid); end
      checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
      checks++; if (clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL reset_clr: got %0b expected 0", clr_rx_rdy); end
      checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL reset_rx_err: got %0b expected 0", rx_err); end
      checks++; if (pix_gray !== 8'd0) begin errors++; $display("FAIL reset_pix: got %0h expected 0", pix_gray); end
      for (int i = 0; i < 20; i++) begin
         read_pix($urandom_range(0, 700), $urandom_range(0, 520), v);
         checks++; if (v !== 8'd0) begin errors++; $display("FAIL reset_sweep: got %0h expected 0", v); end
      end
      do_vsync();
      @(negedge clk);
      checks++; if (frame_cnt !== 8'd0 || frame_valid !== 1'b0) begin
         errors++; $display("FAIL reset_vsync: got cnt %0d valid %0b expected 0 0", frame_cnt, frame_valid); end
   endtask

   task automatic test_frame();
      int px[5] = '{0, 19, 20, 0, 639};
      int py[5] = '{0, 14, 0, 15, 479};
      logic [7:0] pe[5] = '{8'd0, 8'd0, 8'd1, 8'd32, 8'd255};
      logic [7:0] v;
      int c0 = clr_cnt;
      for (int n = 0; n < 1024; n++) send_byte(8'(n % 256));
      do_vsync();
      @(negedge clk);
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL frame_valid: got %0b expected 1", frame_valid); end
      checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL frame_cnt1: got %0d expected 1", frame_cnt); end
      checks++; if (clr_cnt - c0 != 1024) begin errors++; $display("FAIL frame_acks: got %0d expected 1024", clr_cnt - c0); end
      for (int i = 0; i < 5; i++) begin
         read_pix(px[i], py[i], v);
         checks++; if (v !== pe[i]) begin errors++; $display("FAIL frame_point(%0d,%0d): got %0d expected %0d", px[i], py[i], v, pe[i]); end
      end
   endtask

   task automatic test_pipeline();
      int qx[202];
      int qy[202];
      for (int i = 0; i < 202; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            checks++;
            if (pix_gray !== exp_pix(qx[i-2], qy[i-2])) begin
               errors++; $display("FAIL pipeline(%0d,%0d): got %0h expected %0h", qx[i-2], qy[i-2], pix_gray, exp_pix(qx[i-2], qy[i-2]));
            end
         end
         qx[i] = $urandom_range(0, 680);
         qy[i] = $urandom_range(0, 500);
         pix_x = 10'(qx[i]); pix_y = 10'(qy[i]);
      end
   endtask

   task automatic test_pend_drop();
      logic [7:0] v;
      int x, y;
      int e0 = err_cnt;
      int c0 = clr_cnt;
      for (int n = 0; n < 1024; n++) send_byte(8'h55);
      for (int n = 0; n < 3; n++) send_byte(8'h77);
      repeat (2) @(negedge clk);
      checks++; if (err_cnt - e0 != 3) begin errors++; $display("FAIL pend_rx_err: got %0d expected 3", err_cnt - e0); end
      checks++; if (clr_cnt - c0 != 1027) begin errors++; $display("FAIL pend_acks: got %0d expected 1027", clr_cnt - c0); end
      for (int i = 0; i < 20; i++) begin
         x = $urandom_range(0, 639); y = $urandom_range(0, 479);
         read_pix(x, y, v);
         checks++; if (v !== exp_pix(x, y)) begin errors++; $display("FAIL pend_old_frame(%0d,%0d): got %0h expected %0h", x, y, v, exp_pix(x, y)); end
      end
      do_vsync();
      @(negedge clk);
      checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL pend_frame_cnt: got %0d expected 2", frame_cnt); end
      for (int i = 0; i < 30; i++) begin
         x = (i == 0) ? 639 : $urandom_range(0, 639); y = (i == 0) ? 479 : $urandom_range(0, 479);
         read_pix(x, y, v);
         checks++; if (v !== 8'h55) begin errors++; $display("FAIL pend_new_frame(%0d,%0d): got %0h expected 55", x, y, v); end
      end
   endtask

   task automatic test_timeout();
      logic [7:0] v;
      int x, y;
      int e0 = err_cnt;
      int acc;
      for (int n = 0; n < 500; n++) send_byte(8'($urandom));
      acc = last_acc;
      repeat (TO + 10) @(negedge clk);
      ref_idx = 0;
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL timeout_pulses: got %0d expected 1", err_cnt - e0); end
      checks++; if (last_err_cyc - acc != TO + 1) begin
         errors++; $display("FAIL timeout_boundary: got %0d cycles expected %0d", last_err_cyc - acc, TO + 1); end
      for (int n = 0; n < 1024; n++) send_byte(8'hAA);
      do_vsync();
      @(negedge clk);
      checks++; if (frame_cnt !== 8'(ref_cnt)) begin errors++; $display("FAIL timeout_frame_cnt: got %0d expected %0d", frame_cnt, ref_cnt); end
      for (int i = 0; i < 30; i++) begin
         x = $urandom_range(0, 639); y = $urandom_range(0, 479);
         read_pix(x, y, v);
         checks++; if (v !== 8'hAA) begin errors++; $display("FAIL timeout_frame(%0d,%0d): got %0h expected aa", x, y, v); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] v;
      int x, y;
      int e0 = err_cnt;
      int c0 = clr_cnt;
      @(negedge clk);
      rx_rdy = 1'b1; rx_data = 8'h3C;
      repeat (2052) @(negedge clk);
      rx_rdy = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 1024; i++) ref_back[i] = 8'h3C;
      ref_pend = 1; ref_idx = 0;
      checks++; if (clr_cnt - c0 != 1026) begin errors++; $display("FAIL hold_acks: got %0d expected 1026", clr_cnt - c0); end
      checks++; if (err_cnt - e0 != 2) begin errors++; $display("FAIL hold_drops: got %0d expected 2", err_cnt - e0); end
      do_vsync();
      @(negedge clk);
      checks++; if (frame_cnt !== 8'd4) begin errors++; $display("FAIL hold_frame_cnt: got %0d expected 4", frame_cnt); end
      for (int i = 0; i < 20; i++) begin
         x = $urandom_range(0, 639); y = $urandom_range(0, 479);
         read_pix(x, y, v);
         checks++; if (v !== 8'h3C) begin errors++; $display("FAIL hold_frame(%0d,%0d): got %0h expected 3c", x, y, v); end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] v;
      int x, y;
      int ox[3] = '{640, 10, 639};
      int oy[3] = '{10, 480, 479};
      for (int n = 0; n < 700; n++) send_byte(8'h11);
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      checks++; if (frame_valid !== 1'b0 || frame_cnt !== 8'd0) begin
         errors++; $display("FAIL midreset_state: got valid %0b cnt %0d expected 0 0", frame_valid, frame_cnt); end
      read_pix(100, 100, v);
      checks++; if (v !== 8'd0) begin errors++; $display("FAIL midreset_pix: got %0h expected 0", v); end
      for (int n = 0; n < 1024; n++) send_byte(8'($urandom));
      do_vsync();
      @(negedge clk);
      checks++; if (frame_cnt !== 8'd1 || frame_valid !== 1'b1) begin
         errors++; $display("FAIL midreset_frame: got cnt %0d valid %0b expected 1 1", frame_cnt, frame_valid); end
      for (int i = 0; i < 40; i++) begin
         x = $urandom_range(0, 639); y = $urandom_range(0, 479);
         read_pix(x, y, v);
         checks++; if (v !== exp_pix(x, y)) begin errors++; $display("FAIL midreset_image(%0d,%0d): got %0h expected %0h", x, y, v, exp_pix(x, y)); end
      end
      for (int i = 0; i < 3; i++) begin
         read_pix(ox[i], oy[i], v);
         checks++; if (v !== exp_pix(ox[i], oy[i])) begin
            errors++; $display("FAIL edge(%0d,%0d): got %0h expected %0h", ox[i], oy[i], v, exp_pix(ox[i], oy[i])); end
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_pipeline();
      test_pend_drop();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_pipeline();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
